unique_list_streamer: RTL and testbench

- Consumes the compacted unique-value list and `unique_count` produced by the team's duplicate-removal stage.
- Streams the valid entries out one per cycle over a valid/ready interface, with a last flag.
- Sits between the combinational dedup stage and the downstream sequential consumers (UART/FIFO path). It is the reader side of the dedup writer.
- Holds one list at a time and accepts a new list only when idle.

---
 rtl/dedup_pkg.sv | 21 ++
 rtl/unique_list_streamer.sv | 143 ++++++++++++++
 tb/tb_unique_list_streamer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dedup_pkg.sv
// Shared types and sizing for the duplicate-removal path.
// Used by the dedup writer stage and the list streamer.
package dedup_pkg;

  localparam int DATA_W = 8;
  localparam int N      = 9;
  localparam int CNT_W  = 4;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_e;

  function automatic int clamp_count(
    input int count,
    input int n
  );
    return (count > n) ? n : count;
  endfunction

endpackage

// File: rtl/unique_list_streamer.sv
// Reader side of the dedup stage: holds one compacted list
// and streams its valid entries out one per cycle.
module unique_list_streamer #(
  parameter int DATA_W = dedup_pkg::DATA_W,
  parameter int N      = dedup_pkg::N,
  parameter int CNT_W  = dedup_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [N*DATA_W-1:0] list_in,
  input  logic [CNT_W-1:0]    count_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]    out_index,
  output logic                out_last,
  output logic                done,
  output logic                count_err
);
  import dedup_pkg::*;

  state_e state_q, state_d;

  logic [DATA_W-1:0] buf_q [N];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_en;

  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  index_d;
  logic              last_d;
  logic              done_d;
  logic              err_d;
  logic              ready_d;

  logic [CNT_W-1:0]  nxt_idx;
  logic [DATA_W-1:0] nxt_data;

  assign nxt_idx = out_index + 1'b1;

  always_comb begin
    nxt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (nxt_idx == CNT_W'(k)) begin
        nxt_data = buf_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_en = 1'b0;
    valid_d = out_valid;
    data_d  = out_data;
    index_d = out_index;
    last_d  = out_last;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = load_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (load_valid && load_ready) begin
          load_en = 1'b1;
          cnt_d   = CNT_W'(clamp_count(
                      int'(count_in), N));
          err_d   = int'(count_in) > N;
          if (cnt_d == '0) begin
            done_d = 1'b1;
          end else begin
            // slot 0 comes straight from the input:
            // the buffer is written on this same edge
            state_d = ST_STREAM;
            valid_d = 1'b1;
            data_d  = list_in[DATA_W-1:0];
            index_d = '0;
            last_d  = (cnt_d == CNT_W'(1));
            ready_d = 1'b0;
          end
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            index_d = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            data_d  = nxt_data;
            index_d = nxt_idx;
            last_d  = (nxt_idx == cnt_q - 1'b1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      count_err  <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_index  <= index_d;
      out_last   <= last_d;
      done       <= done_d;
      count_err  <= err_d;
      load_ready <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else if (load_en) begin
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= list_in[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_unique_list_streamer.sv
// Self-checking bench for unique_list_streamer: vector table,
// reset corner case and randomized lists against a list model.
module tb_unique_list_streamer;

  localparam int DW = 8;
  localparam int NS = 9;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [NS*DW-1:0] list_in = '0;
  logic [CW-1:0]  count_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_index;
  logic           out_last;
  logic           done;
  logic           count_err;

  unique_list_streamer #(
    .DATA_W(DW),
    .N(NS),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .list_in(list_in),
    .count_in(count_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .done(done),
    .count_err(count_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [NS*DW-1:0] lst;
    int               cnt;
    int               mode;
    bit               hold;
    int               exp_len;
    bit               exp_err;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, ".load_ready"}, 32'(load_ready), 1);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".out_data"}, 32'(out_data), 0);
    chk({tag, ".out_index"}, 32'(out_index), 0);
    chk({tag, ".out_last"}, 32'(out_last), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".count_err"}, 32'(count_err), 0);
  endtask

  // mode 0: ready held, 1: pattern 1,0,0, 2: random
  task automatic run_list(input logic [NS*DW-1:0] lst,
                          input int cnt_in,
                          input int mode,
                          input bit hold,
                          input int exp_len,
                          input bit exp_err);
    int cnt;
    int e;
    int seen;
    bit rdy;
    cnt  = (cnt_in > NS) ? NS : cnt_in;
    e    = 0;
    seen = 0;
    chk("pre.load_ready", 32'(load_ready), 1);
    list_in    = lst;
    count_in   = cnt_in[CW-1:0];
    load_valid = 1'b1;
    out_ready  = 1'b0;
    step();
    if (hold) begin
      list_in  = ~lst;
      count_in = 4'd3;
    end else begin
      load_valid = 1'b0;
    end
    chk("count_err", 32'(count_err), 32'(exp_err));
    if (cnt == 0) begin
      chk("empty.out_valid", 32'(out_valid), 0);
      chk("empty.done", 32'(done), 1);
      chk("empty.load_ready", 32'(load_ready), 1);
      step();
      chk("empty.done_off", 32'(done), 0);
      chk("empty.err_off", 32'(count_err), 0);
      chk("empty.valid_off", 32'(out_valid), 0);
      return;
    end
    for (int c = 0; c < cnt*4 + 10; c++) begin
      chk("out_valid", 32'(out_valid), 1);
      chk("out_data", 32'(out_data),
          32'(lst[e*DW +: DW]));
      chk("out_index", 32'(out_index), e);
      chk("out_last", 32'(out_last),
          32'(e == cnt - 1));
      chk("done_low", 32'(done), 0);
      chk("load_ready_low", 32'(load_ready), 0);
      if (c > 0) chk("err_low", 32'(count_err), 0);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (c % 3 == 0);
      else rdy = ($urandom_range(0, 2) != 0) ||
                 (c >= cnt*2);
      out_ready = rdy;
      step();
      if (rdy) begin
        seen++;
        if (e == cnt - 1) break;
        e++;
      end
    end
    load_valid = 1'b0;
    out_ready  = 1'b0;
    chk("xfer_count", seen, exp_len);
    chk("end.done", 32'(done), 1);
    chk("end.out_valid", 32'(out_valid), 0);
    chk("end.out_last", 32'(out_last), 0);
    chk("end.load_ready", 32'(load_ready), 1);
    step();
    chk("end.done_off", 32'(done), 0);
    chk("end.valid_off", 32'(out_valid), 0);
  endtask

  initial begin
    logic [NS*DW-1:0] l5;
    logic [NS*DW-1:0] rl;
    int rc;
    int rlen;

    l5 = {8'd0, 8'd0, 8'd0, 8'd0,
          8'd67, 8'd45, 8'd33, 8'd22, 8'd15};
    tbl[0] = '{l5, 5, 0, 1'b0, 5, 1'b0};
    tbl[1] = '{l5, 5, 1, 1'b0, 5, 1'b0};
    tbl[2] = '{l5, 0, 0, 1'b0, 0, 1'b0};
    tbl[3] = '{{8'd90, 8'd80, 8'd70, 8'd60, 8'd50,
                8'd40, 8'd30, 8'd20, 8'd10},
               9, 0, 1'b1, 9, 1'b0};
    tbl[4] = '{{8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                8'hd4, 8'hc3, 8'hb2, 8'ha1},
               4, 0, 1'b0, 4, 1'b0};
    tbl[5] = '{{9{8'd5}}, 12, 0, 1'b0, 9, 1'b1};

    #1 rst_n = 1'b0;
    step();
    chk_rst_vals("reset");
    rst_n = 1'b1;
    step();
    chk_rst_vals("post_reset");

    for (int i = 0; i < 6; i++) begin
      run_list(tbl[i].lst, tbl[i].cnt, tbl[i].mode,
               tbl[i].hold, tbl[i].exp_len,
               tbl[i].exp_err);
    end

    // reset in the middle of a 5-entry stream
    list_in    = l5;
    count_in   = 4'd5;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    step();
    chk("mid.out_index", 32'(out_index), 2);
    chk("mid.out_data", 32'(out_data), 33);
    rst_n = 1'b0;
    #1;
    chk_rst_vals("mid_reset");
    #2 rst_n = 1'b1;
    out_ready = 1'b0;
    step();
    chk_rst_vals("after_abort");
    run_list({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
              8'd3, 8'd2, 8'd1}, 3, 0, 1'b0, 3, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < NS; k++) begin
        rl[k*DW +: DW] = 8'($urandom);
      end
      rc   = $urandom_range(0, 15);
      rlen = (rc > NS) ? NS : rc;
      run_list(rl, rc, 2, 1'b0, rlen, rc > NS);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
